// File: rtl/m_dm.sv
// ---------------------------------------------------------------------------
// m_dm : data-memory stage (M) of the 5-stage MIPS pipeline.
//
// Word-organised RAM with byte/half/word stores, sign/zero-extended loads,
// alignment and range checking, and a registered one-cycle write-trace
// record for every committed store.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = reset)
//   in_pc      PC of the instruction in M (trace only)
//   we         store request this cycle
//   mem_op     0=W 1=H 2=HU 3=B 4=BU, 5-7 reserved
//   addr       byte address
//   wdata      store data, low bits used for H/B
//   rdata      extended load data (combinational)
//   align_err  misalignment flag (combinational)
//   range_err  out-of-range / reserved-op flag (combinational)
//   tr_valid   a store committed on the previous edge
//   tr_pc      PC of that store
//   tr_addr    word-aligned byte address written
//   tr_data    full word value after the merge
// ---------------------------------------------------------------------------
module m_dm #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic        we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        range_err,
  output logic        tr_valid,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_addr,
  output logic [31:0] tr_data
);

  localparam int          IDXW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     off;
  logic            below;
  logic            in_range;
  logic            any_err;
  logic            commit;
  logic [IDXW-1:0] idx;
  logic [31:0]     old_word;
  logic [15:0]     old_half;
  logic [7:0]      old_byte;
  logic [31:0]     merged;

  assign off = addr - BASE;

  // With BASE at zero no unsigned address can lie below it, so the
  // comparison is only built when it can actually fire.
  generate
    if (BASE == 32'h0) begin : g_no_base
      assign below = 1'b0;
    end else begin : g_base
      assign below = (addr < BASE);
    end
  endgenerate

  assign range_err = below | (off >= LIMIT) | (mem_op > OP_BU);
  assign align_err = ((mem_op == OP_W) & (addr[1:0] != 2'b00)) |
                     (((mem_op == OP_H) | (mem_op == OP_HU)) & addr[0]);
  assign any_err   = align_err | range_err;
  assign in_range  = ~range_err;
  assign commit    = we & ~any_err;

  // Index is forced to 0 when out of range so the array is never addressed
  // past its last word.
  assign idx      = in_range ? off[IDXW+1:2] : '0;
  assign old_word = mem[idx];
  assign old_half = addr[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    old_byte = old_word[7:0];
    case (addr[1:0])
      2'd1:    old_byte = old_word[15:8];
      2'd2:    old_byte = old_word[23:16];
      2'd3:    old_byte = old_word[31:24];
      default: old_byte = old_word[7:0];
    endcase
  end

  // Load path: reads the pre-write contents, zero on any error or in reset.
  always_comb begin
    rdata = 32'h0;
    if (reset && !any_err) begin
      case (mem_op)
        OP_W:    rdata = old_word;
        OP_H:    rdata = {{16{old_half[15]}}, old_half};
        OP_HU:   rdata = {16'h0, old_half};
        OP_B:    rdata = {{24{old_byte[7]}}, old_byte};
        OP_BU:   rdata = {24'h0, old_byte};
        default: rdata = 32'h0;
      endcase
    end
  end

  // Store merge: replace only the addressed lane(s) of the current word.
  always_comb begin
    merged = old_word;
    case (mem_op)
      OP_W: merged = wdata;
      OP_H, OP_HU: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      OP_B, OP_BU: begin
        case (addr[1:0])
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = old_word;
        endcase
      end
      default: merged = old_word;
    endcase
  end

  // Array and trace registers share one edge; reset wipes both and drops
  // any store that was pending at that moment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
      tr_valid <= 1'b0;
      tr_pc    <= 32'h0;
      tr_addr  <= 32'h0;
      tr_data  <= 32'h0;
    end else begin
      tr_valid <= commit;
      if (commit) begin
        mem[idx] <= merged;
        tr_pc    <= in_pc;
        tr_addr  <= {addr[31:2], 2'b00};
        tr_data  <= merged;
      end
    end
  end

endmodule

// File: tb/tb_m_dm.sv
// ---------------------------------------------------------------------------
// tb_m_dm : self-checking bench for m_dm.
// A directed vector table covers the documented load/store cases, a
// hand-written sequence covers reset in the middle of a store, and a random
// phase is checked against a byte-level memory model.
// ---------------------------------------------------------------------------
module tb_m_dm;

  localparam int DEPTH = 3072;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk;
  logic        reset;
  logic [31:0] in_pc;
  logic        we;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        align_err;
  logic        range_err;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [31:0] tr_addr;
  logic [31:0] tr_data;

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expAlign;
    logic        expRange;
    logic        expTrValid;
    logic [31:0] expTrData;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain byte-addressed memory plus expected trace state.
  logic [7:0]  mb [NBYTES];
  logic        mTrValid;
  logic [31:0] mTrPc;
  logic [31:0] mTrAddr;
  logic [31:0] mTrData;

  m_dm #(.DEPTH_WORDS(DEPTH), .BASE(32'h0)) dut (
    .clk(clk), .reset(reset), .in_pc(in_pc), .we(we), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .align_err(align_err),
    .range_err(range_err), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_addr(tr_addr), .tr_data(tr_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic modelRange(input logic [31:0] a, input logic [2:0] op);
    return (a >= 32'(NBYTES)) || (op > 3'd4);
  endfunction

  function automatic logic modelAlign(input logic [31:0] a, input logic [2:0] op);
    if (op == 3'd0) return (a % 4) != 0;
    if (op == 3'd1 || op == 3'd2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] op);
    int unsigned v;
    if (modelRange(a, op) || modelAlign(a, op)) return 32'h0;
    case (op)
      3'd0: v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
      3'd1: begin v = {mb[a+1], mb[a]}; if (v >= 32768) v = v - 65536; end
      3'd2: v = {mb[a+1], mb[a]};
      3'd3: begin v = mb[a]; if (v >= 128) v = v - 256; end
      default: v = mb[a];
    endcase
    return v;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
    mTrValid = 1'b0;
    mTrPc    = 32'h0;
    mTrAddr  = 32'h0;
    mTrData  = 32'h0;
  endtask

  task automatic modelEdge(input logic w, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] pc);
    int unsigned n;
    int unsigned wa;
    if (w && !modelRange(a, op) && !modelAlign(a, op)) begin
      n = (op == 3'd0) ? 4 : ((op <= 3'd2) ? 2 : 1);
      for (int k = 0; k < n; k++) mb[a + k] = d[8*k +: 8];
      wa = a - (a % 4);
      mTrValid = 1'b1;
      mTrPc    = pc;
      mTrAddr  = wa;
      mTrData  = {mb[wa+3], mb[wa+2], mb[wa+1], mb[wa]};
    end else begin
      mTrValid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] pc);
    @(negedge clk);
    we     = w;
    mem_op = op;
    addr   = a;
    wdata  = d;
    in_pc  = pc;
    #1;
  endtask

  // One full cycle checked against the model: combinational outputs before
  // the edge, trace registers just after it.
  task automatic modelCycle(input logic w, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] pc);
    applyStimulus(w, op, a, d, pc);
    checkOutput("m_rdata", rdata, modelLoad(a, op));
    checkOutput("m_align", {31'h0, align_err}, {31'h0, modelAlign(a, op)});
    checkOutput("m_range", {31'h0, range_err}, {31'h0, modelRange(a, op)});
    modelEdge(w, op, a, d, pc);
    @(posedge clk);
    #1;
    checkOutput("m_tr_valid", {31'h0, tr_valid}, {31'h0, mTrValid});
    checkOutput("m_tr_pc", tr_pc, mTrPc);
    checkOutput("m_tr_addr", tr_addr, mTrAddr);
    checkOutput("m_tr_data", tr_data, mTrData);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rop;
    int          sel;

    reset  = 1'b0;
    we     = 1'b0;
    mem_op = 3'd0;
    addr   = 32'h0;
    wdata  = 32'h0;
    in_pc  = 32'h0;
    modelClear();

    vecs.push_back('{1'b1, 3'd0, 32'h10,   32'h12345678, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678});
    vecs.push_back('{1'b0, 3'd0, 32'h10,   32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd3, 32'h11,   32'h000000AB, 32'h00000056, 1'b0, 1'b0, 1'b1, 32'h1234AB78});
    vecs.push_back('{1'b0, 3'd0, 32'h10,   32'h0,        32'h1234AB78, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h12,   32'h0000BEEF, 32'h00001234, 1'b0, 1'b0, 1'b1, 32'hBEEFAB78});
    vecs.push_back('{1'b0, 3'd0, 32'h10,   32'h0,        32'hBEEFAB78, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h20,   32'h00008080, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00008080});
    vecs.push_back('{1'b0, 3'd3, 32'h20,   32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd4, 32'h20,   32'h0,        32'h00000080, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h20,   32'h0,        32'hFFFF8080, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        32'h00008080, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h22,   32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h20,   32'h0,        32'h00008080, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h21,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h3000, 32'h00000055, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h2FFC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 3'd0, 32'h2FFC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd5, 32'h10,   32'h11111111, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'hFFFFFFFC, 32'h1,    32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h10,   32'h0,        32'hBEEFAB78, 1'b0, 1'b0, 1'b0, 32'h0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tr_valid", {31'h0, tr_valid}, 32'h0);
    checkOutput("rst_tr_data", tr_data, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h0040_0000 + 32'(4*i));
      checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_align", i), {31'h0, align_err}, {31'h0, vecs[i].expAlign});
      checkOutput($sformatf("v%0d_range", i), {31'h0, range_err}, {31'h0, vecs[i].expRange});
      modelEdge(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h0040_0000 + 32'(4*i));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_tr_valid", i), {31'h0, tr_valid}, {31'h0, vecs[i].expTrValid});
      if (vecs[i].expTrValid) begin
        checkOutput($sformatf("v%0d_tr_data", i), tr_data, vecs[i].expTrData);
        checkOutput($sformatf("v%0d_tr_addr", i), tr_addr, {vecs[i].addr[31:2], 2'b00});
        checkOutput($sformatf("v%0d_tr_pc", i), tr_pc, 32'h0040_0000 + 32'(4*i));
      end
    end

    // Reset dropped mid-cycle while a store is pending
    modelCycle(1'b1, 3'd0, 32'h40, 32'hFFFFFFFF, 32'h0040_1000);
    modelCycle(1'b0, 3'd0, 32'h40, 32'h0, 32'h0040_1004);
    applyStimulus(1'b1, 3'd0, 32'h40, 32'h00000001, 32'h0040_1008);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_rdata", rdata, 32'h0);
    checkOutput("mid_rst_tr_valid", {31'h0, tr_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("in_rst_tr_valid", {31'h0, tr_valid}, 32'h0);
    checkOutput("in_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    we    = 1'b0;
    reset = 1'b1;
    modelClear();
    #1;
    checkOutput("post_rst_tr_pc", tr_pc, 32'h0);
    checkOutput("post_rst_tr_addr", tr_addr, 32'h0);
    checkOutput("post_rst_tr_data", tr_data, 32'h0);
    checkOutput("post_rst_lw40", rdata, 32'h0);
    mem_op = 3'd0;
    addr   = 32'h10;
    #1;
    checkOutput("post_rst_lw10", rdata, 32'h0);
    modelCycle(1'b0, 3'd0, 32'h40, 32'h0, 32'h0);

    // Random phase against the byte model
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      ra = $urandom_range(0, 127);
      else if (sel == 7) ra = 32'(NBYTES - 16) + $urandom_range(0, 31);
      else if (sel == 8) ra = $urandom;
      else               ra = 32'hFFFFFFF0 + $urandom_range(0, 15);
      rop = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      modelCycle(1'($urandom_range(0, 1)), rop, ra, $urandom, $urandom);
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
